// File: rtl/display_pkg.sv
// display_pkg: scanner FSM states and the hex to 7-segment table (bit0=a .. bit6=g)
package display_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DWELL
  } state_t;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/hex_to_7seg.sv
// hex_to_7seg: combinational nibble + dp to segment byte, optionally inverted
//   nibble in 4, dp in 1 (becomes bit7), seg out 8
module hex_to_7seg
  import display_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [7:0] raw;
  assign raw = {dp, SEG_LUT[nibble]};
  assign seg = SEG_ACTIVE_LOW ? ~raw : raw;
endmodule

// File: rtl/wb_display_scanner.sv
// wb_display_scanner: multiplexed digit scanner pushing segment bytes to an HC164 shifter over Wishbone
//   host:  i_enable, i_wr_stb, i_wr_digit, i_wr_value (+ i_wr_dp when DISPLAY_DP_EN is defined)
//   wb:    o_wb_cyc, o_wb_stb, o_wb_data, i_wb_ack, i_wb_stall
//   panel: o_digit_sel (one-hot, active-high), o_busy
module wb_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DWELL_CYCLES   = 25000,
  parameter int DWELL_WIDTH    = 15,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_wr_stb,
  input  logic [2:0]            i_wr_digit,
  input  logic [3:0]            i_wr_value,
`ifdef DISPLAY_DP_EN
  input  logic                  i_wr_dp,
`endif
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic [7:0]            o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic                  o_busy
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [3:0] ram [NUM_DIGITS];
  logic [7:0] seg;
  logic dp_bit;
  logic wr_ok;
  assign wr_ok = i_wr_stb && (32'(i_wr_digit) < NUM_DIGITS);
`ifdef DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] dp_r;
  assign dp_bit = dp_r[idx];
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) dp_r <= '0;
    else if (wr_ok) dp_r[IW'(i_wr_digit)] <= i_wr_dp;
`else
  assign dp_bit = 1'b0;
`endif
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) ram[i] <= '0;
    end else if (wr_ok) begin
      ram[IW'(i_wr_digit)] <= i_wr_value;
    end
  hex_to_7seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
    .nibble(ram[idx]),
    .dp    (dp_bit),
    .seg   (seg)
  );
  always_comb begin
    state_n = S_IDLE;
    case (state)
      S_IDLE:      state_n = i_enable ? S_LOAD : S_IDLE;
      S_LOAD:      state_n = S_SEND;
      S_SEND:      state_n = i_wb_stall ? S_SEND : S_WAIT_ACK;
      S_WAIT_ACK:  state_n = i_wb_ack ? S_WAIT_DONE : S_WAIT_ACK;
      S_WAIT_DONE: state_n = i_wb_stall ? S_WAIT_DONE : S_DWELL;
      S_DWELL:     state_n = (cnt != '0) ? S_DWELL : (i_enable ? S_LOAD : S_IDLE);
      default:     state_n = S_IDLE;
    endcase
  end
  // outputs are decoded from the next state so they are registered yet aligned with the state
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_data   <= '0;
      o_digit_sel <= '0;
      o_busy      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= state == S_WAIT_DONE ? DWELL_WIDTH'(DWELL_CYCLES - 1) :
                     state == S_DWELL ? cnt - 1'b1 : cnt;
      if (state == S_DWELL && cnt == '0) idx <= (32'(idx) == NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (state == S_LOAD) o_wb_data <= seg;
      o_wb_cyc    <= state_n == S_SEND || state_n == S_WAIT_ACK;
      o_wb_stb    <= state_n == S_SEND;
      o_digit_sel <= state_n == S_DWELL ? NUM_DIGITS'(1) << idx : '0;
      o_busy      <= state_n != S_IDLE;
    end
endmodule

// File: tb/tb_wb_display_scanner.sv
// tb_wb_display_scanner: randomized shifter responder checked against a digit/idx reference model
module tb_wb_display_scanner;
  localparam int ND = 4;
  localparam int DW = 6;
  localparam logic [7:0] SEG_TAB [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  logic i_clk = 0, i_reset_n = 0, i_enable = 0, i_wr_stb = 0;
  logic [2:0] i_wr_digit = 0;
  logic [3:0] i_wr_value = 0;
  logic i_wb_ack = 0, i_wb_stall = 0;
`ifdef DISPLAY_DP_EN
  logic i_wr_dp = 0;
`endif
  logic o_wb_cyc, o_wb_stb, o_busy;
  logic [7:0] o_wb_data;
  logic [ND-1:0] o_digit_sel;
  int total = 0, bad = 0;
  logic [3:0] ram_m [ND];
  int idx_m = 0;

  wb_display_scanner #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .DWELL_WIDTH(3), .SEG_ACTIVE_LOW(1'b1)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
    .i_wr_stb(i_wr_stb), .i_wr_digit(i_wr_digit), .i_wr_value(i_wr_value),
`ifdef DISPLAY_DP_EN
    .i_wr_dp(i_wr_dp),
`endif
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
    .o_digit_sel(o_digit_sel), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int d);
    return ~SEG_TAB[ram_m[d]];
  endfunction

  task automatic wr(input logic [2:0] d, input logic [3:0] v);
    i_wr_stb = 1; i_wr_digit = d; i_wr_value = v;
    @(negedge i_clk);
    i_wr_stb = 0;
    if (int'(d) < ND) ram_m[d] = v;
  endtask

  task automatic model_reset;
    for (int i = 0; i < ND; i++) ram_m[i] = 0;
    idx_m = 0;
  endtask

  task automatic xfer(input int stalls, input int ack_dly, input int busy_cy, input bit drop_en,
                      input bit do_wr, input logic [2:0] wd, input logic [3:0] wv);
    int n;
    n = 0;
    while (!o_wb_stb && n < 50) begin @(negedge i_clk); n++; end
    if (!o_wb_stb) begin check("stb_timeout", 0, 1); return; end
    check("data", o_wb_data, exp_byte(idx_m));
    check("sel_blank_send", o_digit_sel, 0);
    for (int s = 0; s < stalls; s++) begin
      i_wb_stall = 1;
      @(negedge i_clk);
      check("stb_held", {o_wb_cyc, o_wb_stb}, 2'b11);
    end
    i_wb_stall = 0;
    @(negedge i_clk);
    check("stb_drop", {o_wb_cyc, o_wb_stb}, 2'b10);
    for (int a = 0; a < ack_dly; a++) begin
      @(negedge i_clk);
      check("cyc_wait_ack", {o_wb_cyc, o_wb_stb}, 2'b10);
    end
    i_wb_ack = 1; i_wb_stall = 1;
    if (drop_en) i_enable = 0;
    @(negedge i_clk);
    i_wb_ack = 0;
    check("cyc_drop", {o_wb_cyc, o_wb_stb, o_digit_sel}, 0);
    for (int b = 1; b < busy_cy; b++) begin
      @(negedge i_clk);
      check("sel_blank_busy", {o_wb_stb, o_digit_sel}, 0);
    end
    i_wb_stall = 0;
    @(negedge i_clk);
    n = 0;
    while (o_digit_sel == (ND'(1) << idx_m) && n < DW + 10) begin
      if (n == 0 && do_wr) begin
        i_wr_stb = 1; i_wr_digit = wd; i_wr_value = wv;
      end else i_wr_stb = 0;
      @(negedge i_clk);
      n++;
    end
    i_wr_stb = 0;
    check("dwell_len", n, DW);
    check("sel_clear", o_digit_sel, 0);
    if (do_wr && int'(wd) < ND) ram_m[wd] = wv;
    idx_m = (idx_m + 1) % ND;
  endtask

  initial begin
    int seen;
    model_reset();
    repeat (3) @(negedge i_clk);
    check("reset_out", {o_wb_cyc, o_wb_stb, o_wb_data, o_digit_sel, o_busy}, 0);
    i_reset_n = 1;
    repeat (3) @(negedge i_clk);
    check("idle_no_stb", {o_busy, o_wb_stb}, 0);
    wr(0, 4'h3);
    i_enable = 1;
    @(negedge i_clk);
    check("stb_lat1", o_wb_stb, 0);
    @(negedge i_clk);
    check("stb_lat2", o_wb_stb, 1);
    check("byte_b0", o_wb_data, 8'hB0);
    xfer(0, 0, 32, 0, 0, 0, 0);
    i_enable = 0;
    i_reset_n = 0;
    @(negedge i_clk);
    i_reset_n = 1;
    model_reset();
    wr(0, 4'h1); wr(1, 4'h2); wr(2, 4'hA); wr(3, 4'hF);
    wr(5, 4'h7);
    i_enable = 1;
    xfer(5, 1, 3, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) xfer($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(1, 5), 0, 0, 0, 0);
    xfer(0, 0, 2, 1, 0, 0, 0);
    check("idle_after_drop", {o_busy, o_wb_stb}, 0);
    seen = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_wb_stb || o_busy) seen++;
    end
    check("stays_idle", seen, 0);
    i_enable = 1;
    xfer(0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      xfer($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(1, 8), 0,
           1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    seen = 0;
    while (!o_wb_stb && seen < 50) begin @(negedge i_clk); seen++; end
    check("pre_reset_stb", o_wb_stb, 1);
    i_wb_stall = 1;
    #2 i_reset_n = 0;
    #1 check("async_reset", {o_wb_cyc, o_wb_stb, o_wb_data, o_digit_sel, o_busy}, 0);
    i_wb_stall = 0;
    @(negedge i_clk);
    check("held_reset", {o_wb_cyc, o_wb_stb, o_busy}, 0);
    i_reset_n = 1;
    model_reset();
    xfer(1, 0, 2, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
